// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared widths, state encodings and timeout default for bus_arbiter
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (fetch/data) arbiter onto a single registered bus master port
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_o,
  output logic              err_o
);

  // Counter value on the last bus cycle allowed before the transfer is abandoned.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                if_ack_q, if_ack_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                err_q, err_d;
  logic                if_pend, mem_pend;
  logic                grant_data, grant_fetch;

  // A requester still sees its own ack this cycle, so its held request is not new work.
  assign if_pend  = if_req_i & ~if_ack_q;
  assign mem_pend = mem_req_i & ~mem_ack_q;

  // State register and all registered outputs; reset drops any in-flight cycle silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_FETCH;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_ack_q     <= 1'b0;
      if_data_q    <= '0;
      mem_ack_q    <= 1'b0;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_ack_q     <= if_ack_d;
      if_data_q    <= if_data_d;
      mem_ack_q    <= mem_ack_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the bus until slave ack or timeout, then pulse the owner.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_ack_d     = 1'b0;
    if_data_d    = '0;
    mem_ack_d    = 1'b0;
    mem_rdata_d  = '0;
    err_d        = 1'b0;
    grant_data   = 1'b0;
    grant_fetch  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not win last time goes first.
        grant_data  = mem_pend & (~if_pend | (last_grant_q == GRANT_FETCH));
        grant_fetch = if_pend & ~grant_data;
        if (grant_data) begin
          state_d      = ST_DATA;
          last_grant_d = GRANT_DATA;
          cnt_d        = '0;
          cyc_d        = 1'b1;
          we_d         = mem_we_i;
          sel_d        = mem_sel_i;
          addr_d       = mem_addr_i;
          wdata_d      = mem_wdata_i;
        end else if (grant_fetch) begin
          state_d      = ST_FETCH;
          last_grant_d = GRANT_FETCH;
          cnt_d        = '0;
          cyc_d        = 1'b1;
          we_d         = 1'b0;
          sel_d        = '1;
          addr_d       = if_addr_i;
          wdata_d      = '0;
        end
      end

      ST_FETCH, ST_DATA: begin
        if (bus_ack_i || (cnt_q == TMO_LAST)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          err_d   = ~bus_ack_i;
          if (state_q == ST_FETCH) begin
            if_ack_d  = 1'b1;
            if_data_d = bus_ack_i ? bus_rdata_i : '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = (bus_ack_i && !we_q) ? bus_rdata_i : '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign mem_ack_o   = mem_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign err_o       = err_q;
  assign stallreq_o  = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o, err_o;

  logic        slave_auto = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  int unsigned scnt = 0;

  int tests = 0;
  int fails = 0;
  logic        rand_done = 1'b0;
  logic        prev_cyc = 1'b0;
  logic [68:0] snap = '0;
  logic [32:0] if_q[$];
  logic [32:0] mem_q[$];

  assign bus_ack_i   = slave_auto ? auto_ack : man_ack;
  assign bus_rdata_i = slave_auto ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o), .err_o(err_o)
  );

  // Slave behaviour: ack delay and read data are both a function of the address.
  function automatic int unsigned slave_delay(input logic [31:0] a);
    return int'(a[4:2]);
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Reference result of one request: {err, data}.
  function automatic logic [32:0] expect_of(input logic [31:0] a, input logic fetch, input logic we);
    if (slave_delay(a) >= TMO) return {1'b1, 32'h0};
    if (!fetch && we) return {1'b0, 32'h0};
    return {1'b0, slave_data(a)};
  endfunction

  // Randomized slave: acks on the (delay+1)-th strobe cycle, random stray acks while idle.
  always @(negedge clk) begin
    if (bus_cyc_o) begin
      auto_ack   <= (scnt == slave_delay(bus_addr_o));
      auto_rdata <= (scnt == slave_delay(bus_addr_o)) ? slave_data(bus_addr_o) : $urandom;
      scnt       <= scnt + 1;
    end else begin
      auto_ack   <= ($urandom_range(0, 3) == 0);
      auto_rdata <= $urandom;
      scnt       <= 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // In a cycle where the bus should be owned: check address, ack it, move to the ack_o cycle.
  task automatic serve(input string name, input logic [31:0] exp_addr, input logic [31:0] rdata);
    chk({name, "_cyc"}, bus_cyc_o, 1'b1);
    chk({name, "_addr"}, bus_addr_o, exp_addr);
    man_ack = 1'b1;
    man_rdata = rdata;
    cyc();
    man_ack = 1'b0;
    man_rdata = '0;
  endtask

  task automatic drv_if(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      int w;
      logic [31:0] a;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        if_req_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
      a = $urandom;
      a[1:0] = 2'b00;
      if_addr_i = a;
      if_req_i = 1'b1;
      if_q.push_back(expect_of(a, 1'b1, 1'b0));
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!if_ack_o && w < 100);
      chk("if_wait_bound", if_ack_o, 1'b1);
    end
    if_req_i = 1'b0;
  endtask

  task automatic drv_mem(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      int w;
      logic [31:0] a;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        mem_req_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
      a = $urandom;
      a[1:0] = 2'b00;
      mem_addr_i = a;
      mem_we_i = 1'($urandom_range(0, 1));
      mem_sel_i = 4'($urandom);
      mem_wdata_i = $urandom;
      mem_req_i = 1'b1;
      mem_q.push_back(expect_of(a, 1'b0, mem_we_i));
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!mem_ack_o && w < 100);
      chk("mem_wait_bound", mem_ack_o, 1'b1);
    end
    mem_req_i = 1'b0;
  endtask

  task automatic mon_step();
    logic [32:0] e;
    logic ok;
    if (!if_ack_o) chk("if_data_zero", if_data_o, 32'h0);
    if (!mem_ack_o) chk("mem_rdata_zero", mem_rdata_o, 32'h0);
    chk("ack_exclusive", if_ack_o & mem_ack_o, 1'b0);
    chk("err_needs_ack", err_o & ~if_ack_o & ~mem_ack_o, 1'b0);
    if (if_ack_o) begin
      if (if_q.size() == 0) chk("if_unexpected_ack", 1'b1, 1'b0);
      else begin
        e = if_q.pop_front();
        chk("if_data", if_data_o, e[31:0]);
        chk("if_err", err_o, e[32]);
      end
    end
    if (mem_ack_o) begin
      if (mem_q.size() == 0) chk("mem_unexpected_ack", 1'b1, 1'b0);
      else begin
        e = mem_q.pop_front();
        chk("mem_rdata", mem_rdata_o, e[31:0]);
        chk("mem_err", err_o, e[32]);
      end
    end
    chk("stb_eq_cyc", bus_stb_o, bus_cyc_o);
    if (bus_cyc_o && !prev_cyc) begin
      ok = (if_req_i && bus_addr_o == if_addr_i && !bus_we_o && bus_sel_o == 4'hF) ||
           (mem_req_i && bus_addr_o == mem_addr_i && bus_we_o == mem_we_i &&
            bus_sel_o == mem_sel_i && bus_wdata_o == mem_wdata_i);
      chk("grant_fields", ok, 1'b1);
      snap = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o};
    end else if (bus_cyc_o) begin
      chk("bus_stable", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, snap);
    end
    prev_cyc = bus_cyc_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, '0);
    chk("rst_acks", {if_ack_o, mem_ack_o, err_o, stallreq_o}, '0);
    chk("rst_data", {if_data_o, mem_rdata_o}, '0);
    rst = 1'b0;
    cyc();

    // Single fetch, zero wait states, minimum latency
    if_addr_i = 32'h0000_0100;
    if_req_i = 1'b1;
    #1;
    chk("fetch_stall_req_cycle", stallreq_o, 1'b1);
    cyc();
    chk("fetch_stall_stb_cycle", stallreq_o, 1'b1);
    chk("fetch_we_sel", {bus_we_o, bus_sel_o}, {1'b0, 4'hF});
    chk("fetch_no_early_ack", if_ack_o, 1'b0);
    serve("fetch", 32'h100, 32'h3C01_0001);
    chk("fetch_ack", if_ack_o, 1'b1);
    chk("fetch_data", if_data_o, 32'h3C01_0001);
    chk("fetch_stall_ack_cycle", stallreq_o, 1'b0);
    chk("fetch_cyc_drop", bus_cyc_o, 1'b0);
    if_req_i = 1'b0;
    cyc();
    chk("fetch_ack_one_cycle", {if_ack_o, if_data_o}, '0);

    // Ties: data first out of reset, then alternation
    if_addr_i = 32'h200;
    mem_addr_i = 32'h300;
    mem_we_i = 1'b0;
    mem_sel_i = 4'hF;
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    cyc();
    serve("tie1_data_first", 32'h300, 32'h1111_1111);
    chk("tie1_mem_ack", {mem_ack_o, if_ack_o, mem_rdata_o}, {2'b10, 32'h1111_1111});
    mem_req_i = 1'b0;
    cyc();
    serve("tie1_fetch_second", 32'h200, 32'h2222_2222);
    chk("tie1_if_ack", {if_ack_o, if_data_o}, {1'b1, 32'h2222_2222});
    if_req_i = 1'b0;
    cyc();
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    cyc();
    serve("tie2_data_again", 32'h300, 32'h3333_3333);
    chk("tie2_mem_ack", mem_ack_o, 1'b1);
    mem_req_i = 1'b0;
    cyc();
    serve("tie2_fetch", 32'h200, 32'h4444_4444);
    chk("tie2_if_ack", if_ack_o, 1'b1);
    if_req_i = 1'b0;
    mem_req_i = 1'b1;
    cyc();
    cyc();
    serve("solo_data", 32'h300, 32'h5555_5555);
    chk("solo_mem_ack", mem_ack_o, 1'b1);
    mem_req_i = 1'b0;
    cyc();
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    cyc();
    serve("tie3_fetch_wins", 32'h200, 32'h6666_6666);
    chk("tie3_if_ack", if_ack_o, 1'b1);
    if_req_i = 1'b0;
    cyc();
    serve("tie3_data", 32'h300, 32'h7777_7777);
    chk("tie3_mem_ack", mem_ack_o, 1'b1);
    mem_req_i = 1'b0;
    cyc();

    // Store with three wait states; ack lands on the last cycle before timeout
    mem_we_i = 1'b1;
    mem_sel_i = 4'b0011;
    mem_addr_i = 32'h80;
    mem_wdata_i = 32'hDEAD_BEEF;
    mem_req_i = 1'b1;
    man_rdata = 32'hFFFF_FFFF;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("store_bus_stable", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o},
          {3'b111, 4'b0011, 32'h80, 32'hDEAD_BEEF});
      man_ack = (k == 3);
      cyc();
    end
    man_ack = 1'b0;
    man_rdata = '0;
    chk("store_ack", {mem_ack_o, err_o, bus_cyc_o}, 3'b100);
    chk("store_rdata_zero", mem_rdata_o, 32'h0);
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    cyc();

    // Fetch with no slave response: abort after TMO cycles
    if_addr_i = 32'h400;
    if_req_i = 1'b1;
    man_rdata = 32'hCAFE_F00D;
    cyc();
    for (int k = 0; k < int'(TMO); k++) begin
      chk("tmo_cyc_held", bus_cyc_o, 1'b1);
      cyc();
    end
    chk("tmo_abort", {bus_cyc_o, if_ack_o, err_o}, 3'b011);
    chk("tmo_data_zero", if_data_o, 32'h0);
    if_req_i = 1'b0;
    man_rdata = '0;
    cyc();
    chk("tmo_err_one_cycle", {err_o, if_ack_o}, 2'b00);

    // Reset during a data wait: everything clears, no ack, request re-issued afterwards
    mem_addr_i = 32'h500;
    mem_sel_i = 4'hF;
    mem_req_i = 1'b1;
    cyc();
    chk("rstmid_cyc", bus_cyc_o, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rstmid_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, '0);
    chk("rstmid_acks", {if_ack_o, mem_ack_o, err_o, if_data_o, mem_rdata_o}, '0);
    rst = 1'b0;
    cyc();
    chk("rstmid_no_ack", mem_ack_o, 1'b0);
    serve("rstmid_reissue", 32'h500, 32'h8888_8888);
    chk("rstmid_reissue_ack", {mem_ack_o, mem_rdata_o}, {1'b1, 32'h8888_8888});
    mem_req_i = 1'b0;
    cyc();

    // last_grant returns to FETCH on reset, so data wins the next tie
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    if_addr_i = 32'h600;
    mem_addr_i = 32'h700;
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    cyc();
    serve("post_rst_tie_data", 32'h700, 32'h9999_9999);
    chk("post_rst_mem_ack", mem_ack_o, 1'b1);
    mem_req_i = 1'b0;
    cyc();
    serve("post_rst_fetch", 32'h600, 32'hAAAA_AAAA);
    chk("post_rst_if_ack", if_ack_o, 1'b1);
    if_req_i = 1'b0;
    cyc();

    // Stray slave ack while idle has no effect
    man_ack = 1'b1;
    man_rdata = 32'h77;
    cyc();
    cyc();
    chk("idle_ack_ignored", {if_ack_o, mem_ack_o, err_o, bus_cyc_o}, 4'b0000);
    man_ack = 1'b0;
    man_rdata = '0;
    cyc();

    // Randomized concurrent traffic against the reference scoreboard
    slave_auto = 1'b1;
    prev_cyc = 1'b0;
    fork
      begin
        fork
          drv_if(60);
          drv_mem(60);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          mon_step();
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("if_queue_drained", if_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
